// File: rtl/tx_gearbox.sv
// -----------------------------------------------------------------------------
// tx_gearbox
// 64b/66b transmit gearbox: packs 66-bit blocks, delivered as two 32-bit halves
// with the sync header on the first half, into a continuous 32-bit word stream.
// Upstream is paused for one cycle in every 33 to drain the 32 residual bits.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_hdr_valid,
  output logic                  o_data_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_align_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] SEQ_LAST = 6'd32;

  state_t      state_q;
  logic [5:0]  seq_q, seq_d;
  logic [5:0]  r_q, r_d;          // residual bit count held in buf_q
  logic [31:0] buf_q, buf_d;      // residual bits, stream order from bit 0
  logic [31:0] data_q, word_d;
  logic        valid_q;
  logic        align_err_q, align_err_d;
  logic [63:0] w_new;
  logic [63:0] w_comb;

  // Upstream may present a half every RUN cycle except the drain slot.
  assign o_data_ready = (state_q == RUN) && (seq_q != SEQ_LAST);

  // Append this cycle's bits above the residual and split off the low word.
  // Residual is at most 30 bits on header cycles, so 34 new bits fit in 64.
  always_comb begin
    seq_d       = seq_q;
    r_d         = r_q;
    buf_d       = buf_q;
    word_d      = '0;
    align_err_d = 1'b0;
    w_new       = '0;
    w_comb      = {32'b0, buf_q};
    if (state_q == RUN) begin
      seq_d = (seq_q == SEQ_LAST) ? 6'd0 : seq_q + 6'd1;
      if (seq_q == SEQ_LAST) begin
        word_d = buf_q;
        buf_d  = '0;
        r_d    = '0;
      end else begin
        if (!seq_q[0]) begin
          w_new = {30'b0, i_data, i_hdr};
        end else begin
          w_new = {32'b0, i_data};
        end
        w_comb      = {32'b0, buf_q} | (w_new << r_q);
        word_d      = w_comb[31:0];
        buf_d       = w_comb[63:32];
        r_d         = seq_q[0] ? r_q : r_q + 6'd2;
        // Internal phase wins; a disagreeing marker is only reported.
        align_err_d = (i_hdr_valid != !seq_q[0]);
      end
    end
  end

  // State machine, counters, residual buffer and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      r_q         <= '0;
      buf_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= RUN;
      seq_q       <= seq_d;
      r_q         <= r_d;
      buf_q       <= buf_d;
      data_q      <= word_d;
      valid_q     <= (state_q == RUN);
      align_err_q <= align_err_d;
    end
  end

`ifndef SYNTHESIS
  // The drain slot must always find exactly one full word of residual.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && state_q == RUN && seq_q == SEQ_LAST) begin
      assert (r_q == 6'd32);
    end
  end
`endif

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_align_err  = align_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_gearbox.sv
// -----------------------------------------------------------------------------
// tb_tx_gearbox
// Randomised bench for tx_gearbox against a bit-queue model of the 66b stream.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_tx_gearbox;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] i_data = '0;
  logic [1:0]  i_hdr = '0;
  logic        i_hdr_valid = 1'b0;
  logic        o_data_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_align_err;

  tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_data       (i_data),
    .i_hdr        (i_hdr),
    .i_hdr_valid  (i_hdr_valid),
    .o_data_ready (o_data_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_align_err  (o_align_err)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Model: serial bit stream as a queue; phase from count of accepted halves.
  bit          m_q[$];
  bit          out_bits[$];
  bit          m_run = 1'b0;
  int          m_idx = 0;
  int          m_acc = 0;
  logic [31:0] m_last = '0;
  int          n_low = 0;
  int          n_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    out_bits.delete();
    m_run = 1'b0;
    m_idx = 0;
    m_acc = 0;
  endtask

  // One clock cycle with current inputs; checks before and after the edge.
  task automatic cycle();
    logic        exp_rdy;
    logic [31:0] exp_w;
    logic        exp_err;
    exp_rdy = m_run && ((m_idx % 33) != 32);
    exp_err = 1'b0;
    exp_w   = '0;
    chk("ready", {31'b0, o_data_ready}, {31'b0, exp_rdy});
    if (m_run) begin
      if (!o_data_ready) n_low++; else n_acc++;
      if (exp_rdy) begin
        if ((m_acc % 2) == 0) begin
          m_q.push_back(i_hdr[0]);
          m_q.push_back(i_hdr[1]);
        end
        for (int b = 0; b < 32; b++) m_q.push_back(i_data[b]);
        exp_err = (i_hdr_valid != ((m_acc % 2) == 0));
        m_acc++;
      end
      if (m_q.size() < 32) begin
        chk("model_underflow", m_q.size(), 32);
      end else begin
        for (int b = 0; b < 32; b++) exp_w[b] = m_q.pop_front();
      end
    end
    m_last = exp_w;
    @(posedge i_clk);
    #1;
    chk("data", o_data, exp_w);
    chk("valid", {31'b0, o_data_valid}, {31'b0, m_run});
    chk("align_err", {31'b0, o_align_err}, {31'b0, exp_err});
    if (m_run) begin
      for (int b = 0; b < 32; b++) out_bits.push_back(o_data[b]);
      m_idx++;
    end else begin
      m_run = 1'b1;
    end
  endtask

  task automatic rnd(input int n, input int err_pct);
    for (int i = 0; i < n; i++) begin
      i_data      = $urandom;
      i_hdr       = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      i_hdr_valid = ((m_acc % 2) == 0);
      if ($urandom_range(0, 99) < err_pct) i_hdr_valid = ~i_hdr_valid;
      cycle();
    end
  endtask

  // Every 66-bit slot of the captured stream must start with a legal header.
  task automatic hdr_scan(input string nm);
    int nbad;
    int nfound;
    nbad   = 0;
    nfound = 0;
    for (int k = 0; 66 * k + 65 < out_bits.size(); k++) begin
      nfound++;
      if (out_bits[66*k] == out_bits[66*k+1]) nbad++;
    end
    chk(nm, nbad, 0);
    chk({nm, "_found"}, {31'b0, (nfound > 10)}, 32'd1);
  endtask

  task automatic zero_outputs(input string nm);
    chk({nm, "_ready"}, {31'b0, o_data_ready}, 0);
    chk({nm, "_data"}, o_data, 0);
    chk({nm, "_valid"}, {31'b0, o_data_valid}, 0);
    chk({nm, "_err"}, {31'b0, o_align_err}, 0);
  endtask

  initial begin
    // Reset held: outputs at reset values.
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    zero_outputs("reset");
    i_reset_n = 1'b1;

    // Idle cycle (ready 0), then RUN.
    cycle();

    // Directed all-ones block with header 10.
    i_hdr = 2'b10; i_data = 32'hFFFF_FFFF; i_hdr_valid = 1'b1;
    cycle();
    chk("ones_w0", o_data, 32'hFFFF_FFFE);
    chk("ones_w0_model", m_last, 32'hFFFF_FFFE);
    i_hdr_valid = 1'b0;
    cycle();
    chk("ones_w1", o_data, 32'hFFFF_FFFF);
    chk("ones_w1_model", m_last, 32'hFFFF_FFFF);
    rnd(31, 0);

    // 16 blocks hdr=01, data=0: word j holds 1<<j for even j < 32.
    for (int j = 0; j < 33; j++) begin
      logic [31:0] lit;
      i_hdr = 2'b01; i_data = '0; i_hdr_valid = ((m_acc % 2) == 0);
      lit = ((j % 2) == 0 && j < 32) ? (32'd1 << j) : 32'd0;
      cycle();
      chk("zero_blk", o_data, lit);
      chk("zero_blk_model", m_last, lit);
    end

    // 330 free-running cycles: 10 pauses, 320 halves accepted.
    n_low = 0; n_acc = 0;
    rnd(330, 0);
    chk("pause_count", n_low, 10);
    chk("accept_count", n_acc, 320);

    // Single misaligned marker at seq 0.
    i_data = $urandom; i_hdr = 2'b10; i_hdr_valid = 1'b0;
    cycle();
    chk("align_pulse", {31'b0, o_align_err}, 1);
    i_data = $urandom; i_hdr_valid = 1'b0;
    cycle();
    chk("align_clear", {31'b0, o_align_err}, 0);
    rnd(200, 10);
    hdr_scan("hdr_lock");

    // Reset mid-stream at seq 17.
    while ((m_idx % 33) != 17) rnd(1, 0);
    i_reset_n = 1'b0;
    #1;
    zero_outputs("midreset");
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    zero_outputs("midreset_hold");
    model_reset();
    i_reset_n = 1'b1;
    cycle();
    rnd(100, 0);
    chk("restart_hdr", {31'b0, (out_bits[0] != out_bits[1])}, 1);
    hdr_scan("hdr_relock");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
